// File: rtl/pipe_pkg.sv
// Shared types and default widths for the two-entry skid pipeline stage.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 5;
  localparam int PIPE_TAG_W  = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occupancy_of(input state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream valid-ready bundle for the skid stage; slave is the stage side.
interface pipe_stage_skid_if import pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int TAG_W  = PIPE_TAG_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_ctrl, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_tag
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline register: valid flag plus payload, control and tag.
// Clear wins over load and zeroes the control bits so an empty slot never carries live control.
module pipe_slot import pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int TAG_W  = PIPE_TAG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [TAG_W-1:0]  load_tag,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [TAG_W-1:0]  tag
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
      tag   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
      tag   <= load_tag;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a head register and a skid register.
//   state  | meaning
//   EMPTY  | no entries held
//   ONE    | head holds an entry, skid empty
//   TWO    | head and skid both hold entries, upstream stalled
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int TAG_W  = PIPE_TAG_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  pipe_stage_skid_if.slave     bus
);

  state_t state_q, state_d;
  logic   in_ready_q;
  logic   accept, consume;
  logic   head_load, head_clear, skid_load, skid_clear;

  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data, head_src_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_src_ctrl;
  logic [TAG_W-1:0]  head_tag, skid_tag, head_src_tag;

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = head_valid && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d    = state_q;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (consume) begin
            head_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_ONE;
          end
        end
        default: begin
          head_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ST_EMPTY;
        end
      endcase
    end
  end

  // Head refills from the skid whenever the skid is occupied, else straight from upstream.
  assign head_src_data = skid_valid ? skid_data : bus.in_data;
  assign head_src_ctrl = skid_valid ? skid_ctrl : bus.in_ctrl;
  assign head_src_tag  = skid_valid ? skid_tag  : bus.in_tag;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W)
  ) u_head (
    .clock     (clock),
    .reset     (reset),
    .load      (head_load),
    .clear     (head_clear),
    .load_data (head_src_data),
    .load_ctrl (head_src_ctrl),
    .load_tag  (head_src_tag),
    .valid     (head_valid),
    .data      (head_data),
    .ctrl      (head_ctrl),
    .tag       (head_tag)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (bus.in_data),
    .load_ctrl (bus.in_ctrl),
    .load_tag  (bus.in_tag),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl),
    .tag       (skid_tag)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.out_ctrl  = head_ctrl;
  assign bus.out_tag   = head_tag;
  assign occupancy     = occupancy_of(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed corner cases followed by random valid/ready/flush traffic.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  ctrl;
    logic [4:0]  tag;
  } ent_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occupancy;
  logic       model_rdy = 1'b0;
  int         checks = 0;
  int         errors = 0;
  ent_t       sb[$];

  pipe_stage_skid_if bus ();

  pipe_stage_skid dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .occupancy (occupancy),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of capacity two; ready means fewer than two held.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sb.delete();
      model_rdy <= 1'b0;
    end else begin
      if (flush) sb.delete();
      else if (bus.in_valid && model_rdy) sb.push_back({bus.in_data, bus.in_ctrl, bus.in_tag});
      model_rdy <= (sb.size() < 2);
    end
  end

  // Monitor: compare the presented head with the oldest expected entry, retire on consume.
  always @(negedge clock) begin
    if (!reset) begin
      check("in_ready", 32'(bus.in_ready), 32'(model_rdy));
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      if (!bus.out_valid) begin
        check("idle_ctrl", 32'(bus.out_ctrl), 32'd0);
      end else if (sb.size() != 0) begin
        check("data", bus.out_data, sb[0].data);
        check("ctrl", 32'(bus.out_ctrl), 32'(sb[0].ctrl));
        check("tag", 32'(bus.out_tag), 32'(sb[0].tag));
        if (bus.out_ready && !flush) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] c,
                       input logic [4:0] t, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.in_tag    = t;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        have;
    logic        prev_rdy;
    logic [31:0] rd;
    logic [4:0]  rc, rt;

    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0);
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    step();
    reset = 1'b0;
    check("ready_before_edge", 32'(bus.in_ready), 32'd0);
    step();
    check("ready_after_edge", 32'(bus.in_ready), 32'd1);

    // pass-through
    drive(1'b1, 32'h0000_00AA, 5'b00001, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b1, 1'b0);
    check("pass_valid", 32'(bus.out_valid), 32'd1);
    check("pass_data", bus.out_data, 32'hAA);
    check("pass_occ", 32'(occupancy), 32'd1);
    step();
    check("pass_drain", 32'(occupancy), 32'd0);

    // back-pressure
    drive(1'b1, 32'h11, 5'b00010, 5'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 5'b00100, 5'd2, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0);
    check("bp_occ", 32'(occupancy), 32'd2);
    check("bp_ready", 32'(bus.in_ready), 32'd0);
    check("bp_head", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    step();
    check("bp_second", bus.out_data, 32'h22);
    check("bp_occ1", 32'(occupancy), 32'd1);
    step();
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // flush while full, with an entry offered
    drive(1'b1, 32'h66, 5'b01000, 5'd6, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h77, 5'b10000, 5'd7, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h33, 5'b11111, 5'd9, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b1, 1'b0);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_ctrl", 32'(bus.out_ctrl), 32'd0);
    step();
    check("flush_no_c", 32'(bus.out_valid), 32'd0);

    // simultaneous accept and consume in ONE
    drive(1'b1, 32'h44, 5'b00011, 5'd4, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h55, 5'b00101, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0);
    check("swap_data", bus.out_data, 32'h55);
    check("swap_occ", 32'(occupancy), 32'd1);
    bus.out_ready = 1'b1;
    step();

    // asynchronous reset while full
    drive(1'b1, 32'h88, 5'b00110, 5'd8, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h99, 5'b01100, 5'd10, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b0, 1'b0);
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", bus.out_data, 32'd0);
    check("arst_ctrl", 32'(bus.out_ctrl), 32'd0);
    check("arst_tag", 32'(bus.out_tag), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    check("arst_ready_hold", 32'(bus.in_ready), 32'd0);
    step();
    check("arst_ready_up", 32'(bus.in_ready), 32'd1);
    check("arst_empty", 32'(bus.out_valid), 32'd0);

    // random traffic; upstream holds an offered entry until it is taken
    have = 1'b0;
    rd = '0; rc = '0; rt = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 99) < 60);
        rd   = $urandom;
        rc   = 5'($urandom);
        rt   = 5'($urandom);
      end
      drive(have, rd, rc, rt, $urandom_range(0, 99) < 55, $urandom_range(0, 63) == 0);
      prev_rdy = bus.in_ready;
      step();
      if (flush || (have && prev_rdy)) have = 1'b0;
    end

    drive(1'b0, 32'h0, 5'h0, 5'h0, 1'b1, 1'b0);
    repeat (4) step();
    check("final_empty", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width (e.g. ALU result, store data, branch target).
REQ-002 SHALL have parameter CTRL_W, default 5, meaning control-bit width (branch, memread, memtoreg, memwrite, regwrite).
REQ-003 SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-004 SHALL have port clock  input  1  the single clock; every register updates on the posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  the upstream stage presents an entry.
REQ-007 SHALL have port in_ready  output  1  the stage accepts an entry this cycle; registered, with no combinational path from out_ready.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 SHALL have port in_tag  input  TAG_W  upstream destination tag.
REQ-011 SHALL have port out_valid  output  1  the head entry is valid.
REQ-012 SHALL have port out_ready  input  1  the downstream stage consumes the head entry.
REQ-013 SHALL have port out_data  output  DATA_W  head payload.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  head control bits; all zero whenever out_valid=0.
REQ-015 SHALL have port out_tag  output  TAG_W  head destination tag.
REQ-016 SHALL have port flush  input  1  synchronous kill of every held entry (branch taken, exception).
REQ-017 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-018 SHALL hold at most two entries: a head register that drives the outputs, and a skid register.
REQ-019 SHALL implement states EMPTY (0 entries), ONE (head only) and TWO (head plus skid).
REQ-020 SHALL define accept = in_valid && in_ready and consume = out_valid && out_ready.
REQ-021 SHALL drive in_ready = 1 in EMPTY and ONE, and in_ready = 0 in TWO.
REQ-022 SHALL make these transitions:
- EMPTY + accept -> ONE.
- ONE + accept, no consume -> TWO.
- ONE + consume, no accept -> EMPTY.
- ONE + accept + consume -> ONE (head is replaced by the new entry).
- TWO + consume -> ONE (skid moves to head).
REQ-023 SHALL give one-cycle latency: an entry accepted at edge N appears on the outputs after edge N when the stage was EMPTY, or when it was ONE with a consume.
REQ-024 SHALL preserve FIFO order; no entry is lost or duplicated under any pattern of valid/ready.
REQ-025 SHALL hold out_data, out_ctrl and out_tag stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush=1 at an edge, go to EMPTY and clear the control bits of both registers to zero.
REQ-027 SHALL give flush priority over accept and consume in the same cycle; the incoming entry is discarded.
REQ-028 SHALL keep payload and tag of invalid registers don't-care, and control bits of invalid registers zero.
REQ-029 SHALL drive occupancy as 0, 1 or 2, matching EMPTY, ONE or TWO.
REQ-030 SHALL ignore in_valid while in_ready=0; the upstream stage holds its entry.

Reset
REQ-031 SHALL, on reset assertion and independent of clock, go to EMPTY with out_valid=0, out_ctrl=0, out_data=0, out_tag=0, occupancy=0 and in_ready=0.
REQ-032 SHALL drive in_ready=1 from the first posedge after reset deasserts.
REQ-033 SHALL, on reset mid-transfer, drop all held entries; no entry survives a reset.

Structure
REQ-034 SHALL take its state enum (EMPTY/ONE/TWO) and the default widths from a shared package pipe_pkg.
REQ-035 SHALL build each register from one sub-module, pipe_slot (valid, data, ctrl and tag with load and clear), instantiated twice.

Verification
REQ-036 SHALL cover pass-through: out_ready=1 held, in_data=0x0000_00AA, ctrl=5'b00001 at edge 1 -> out_valid=1 with 0xAA after edge 1, occupancy=1.
REQ-037 SHALL cover back-pressure: out_ready=0, entries A=0x11 then B=0x22 -> occupancy=2, in_ready=0; then out_ready=1 -> A leaves, then B, with no loss.
REQ-038 SHALL cover flush while full: state TWO, flush=1 with in_valid=1 (C=0x33) -> EMPTY, out_valid=0, out_ctrl=0, and C never appears.
REQ-039 SHALL cover simultaneous accept and consume in ONE: head=0x44, incoming 0x55, out_ready=1 -> head=0x55 next cycle, occupancy stays 1.
REQ-040 SHALL cover asynchronous reset mid-cycle in TWO -> outputs zero immediately with no clock edge, and in_ready=1 after the first posedge following deassertion.
REQ-041 SHALL cover random valid/ready for 10k cycles against a scoreboard -> order preserved, and out_ctrl=0 whenever out_valid=0.
